// File: rtl/fcore_isa_pkg.sv
// rtl/fcore_isa_pkg.sv - fCore logic-unit opcode constants, tag type and opcode check
package fcore_isa;

    localparam int unsigned LU_ID_W   = 3;
    localparam int unsigned LU_OP_AND = 0;
    localparam int unsigned LU_OP_OR  = 1;
    localparam int unsigned LU_OP_NOT = 2;
    localparam int unsigned LU_OP_XOR = 6;

    typedef struct packed {
        logic               valid;
        logic [LU_ID_W-1:0] id;
        logic               err;
    } lu_tag_t;

    function automatic logic is_logic_opcode(input int unsigned op);
        return (op == LU_OP_AND) || (op == LU_OP_OR) || (op == LU_OP_NOT) || (op == LU_OP_XOR);
    endfunction

endpackage

// File: rtl/fcore_rr_arbiter.sv
// rtl/fcore_rr_arbiter.sv - combinational round-robin select starting after rr_ptr_i
module fcore_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         eligible_i,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic [$clog2(N_REQ)-1:0] grant_idx_o,
    output logic                     grant_valid_o
);

    localparam int IDX_W = $clog2(N_REQ);

    always_comb begin
        int                 j;
        logic [IDX_W-1:0]   jj;
        j             = 0;
        jj            = '0;
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            j  = (int'(rr_ptr_i) + k) % N_REQ;
            jj = IDX_W'(j);
            if (!grant_valid_o && eligible_i[jj]) begin
                grant_valid_o = 1'b1;
                grant_o[jj]   = 1'b1;
                grant_idx_o   = jj;
            end
        end
    end

endmodule

// File: rtl/fcore_logic_arbiter.sv
// rtl/fcore_logic_arbiter.sv - shares one fCore logic unit between N_REQ issue ports
// Optional perf_grants/perf_stalls counters when FCORE_LOGIC_ARB_PERF_EN is defined.
module fcore_logic_arbiter
    import fcore_isa::*;
#(
    parameter int N_REQ        = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int USER_WIDTH   = 16,
    parameter int OPCODE_WIDTH = 4,
    parameter int LU_LATENCY   = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ*OPCODE_WIDTH-1:0]  req_opcode,
    input  logic [N_REQ*DATA_WIDTH-1:0]    req_operand_a,
    input  logic [N_REQ*DATA_WIDTH-1:0]    req_operand_b,
    input  logic [N_REQ*USER_WIDTH-1:0]    req_user,
    output logic                           lu_valid,
    output logic [DATA_WIDTH-1:0]          lu_operand_a,
    output logic [DATA_WIDTH-1:0]          lu_operand_b,
    output logic [USER_WIDTH-1:0]          lu_user,
    output logic [OPCODE_WIDTH-1:0]        lu_opcode,
    input  logic                           lu_result_valid,
    input  logic [DATA_WIDTH-1:0]          lu_result_data,
    input  logic [USER_WIDTH-1:0]          lu_result_user,
    output logic [N_REQ-1:0]               rsp_valid,
    output logic [N_REQ-1:0]               rsp_error,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic [USER_WIDTH-1:0]          rsp_user,
`ifdef FCORE_LOGIC_ARB_PERF_EN
    output logic [N_REQ*32-1:0]            perf_grants,
    output logic [N_REQ*32-1:0]            perf_stalls,
`endif
    output logic                           protocol_error
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int DEPTH  = LU_LATENCY + 1;
    localparam int MASK_W = $clog2(LU_LATENCY + 2);

    logic [N_REQ-1:0]        pending_q, pending_d, eligible, grant, rsp_onehot;
    logic [IDX_W-1:0]        rr_ptr_q, gnt_idx;
    logic                    hs, legal, mismatch;
    logic [OPCODE_WIDTH-1:0] sel_opcode;
    logic [DATA_WIDTH-1:0]   sel_a, sel_b;
    logic [USER_WIDTH-1:0]   sel_user;
    lu_tag_t                 new_tag, tag_exit;
    lu_tag_t                 tag_q      [DEPTH];
    logic [USER_WIDTH-1:0]   tag_user_q [DEPTH];

    logic                    lu_valid_q;
    logic [DATA_WIDTH-1:0]   lu_a_q, lu_b_q, rsp_data_q;
    logic [USER_WIDTH-1:0]   lu_user_q, rsp_user_q;
    logic [OPCODE_WIDTH-1:0] lu_opcode_q;
    logic [N_REQ-1:0]        rsp_valid_q, rsp_error_q;
    logic                    perr_q;
    logic [MASK_W-1:0]       mask_q;

    assign eligible = req_valid & ~pending_q;

    fcore_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .eligible_i    (eligible),
        .rr_ptr_i      (rr_ptr_q),
        .grant_o       (grant),
        .grant_idx_o   (gnt_idx),
        .grant_valid_o (hs)
    );

    assign req_ready  = grant;
    assign sel_opcode = req_opcode[gnt_idx*OPCODE_WIDTH +: OPCODE_WIDTH];
    assign sel_a      = req_operand_a[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_b      = req_operand_b[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_user   = req_user[gnt_idx*USER_WIDTH +: USER_WIDTH];
    assign legal      = is_logic_opcode(32'(sel_opcode));

    always_comb begin
        new_tag.valid = hs;
        new_tag.id    = LU_ID_W'(gnt_idx);
        new_tag.err   = hs & ~legal;
    end

    assign tag_exit   = tag_q[DEPTH-1];
    assign rsp_onehot = tag_exit.valid ? (N_REQ'(1) << tag_exit.id) : '0;
    // Set wins over clear so a same-cycle re-issue keeps the requester blocked.
    assign pending_d  = (pending_q & ~rsp_onehot) | grant;
    assign mismatch   = (lu_result_valid & (~tag_exit.valid | tag_exit.err))
                      | (tag_exit.valid & ~tag_exit.err & ~lu_result_valid);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q   <= '0;
            rr_ptr_q    <= IDX_W'(N_REQ - 1);
            for (int s = 0; s < DEPTH; s++) begin
                tag_q[s]      <= '0;
                tag_user_q[s] <= '0;
            end
            lu_valid_q  <= 1'b0;
            lu_a_q      <= '0;
            lu_b_q      <= '0;
            lu_user_q   <= '0;
            lu_opcode_q <= '0;
            rsp_valid_q <= '0;
            rsp_error_q <= '0;
            rsp_data_q  <= '0;
            rsp_user_q  <= '0;
            perr_q      <= 1'b0;
            mask_q      <= MASK_W'(LU_LATENCY + 1);
        end else begin
            pending_q <= pending_d;
            if (hs) rr_ptr_q <= gnt_idx;
            tag_q[0]      <= new_tag;
            tag_user_q[0] <= sel_user;
            for (int s = 1; s < DEPTH; s++) begin
                tag_q[s]      <= tag_q[s-1];
                tag_user_q[s] <= tag_user_q[s-1];
            end
            lu_valid_q  <= hs & legal;
            lu_a_q      <= (hs & legal) ? sel_a      : '0;
            lu_b_q      <= (hs & legal) ? sel_b      : '0;
            lu_user_q   <= (hs & legal) ? sel_user   : '0;
            lu_opcode_q <= (hs & legal) ? sel_opcode : '0;
            rsp_valid_q <= rsp_onehot;
            rsp_error_q <= tag_exit.err ? rsp_onehot : '0;
            rsp_data_q  <= (tag_exit.valid & ~tag_exit.err) ? lu_result_data : '0;
            rsp_user_q  <= !tag_exit.valid ? '0 :
                           tag_exit.err    ? tag_user_q[DEPTH-1] : lu_result_user;
            // Unit results still draining from before reset are ignored here.
            if (mask_q != '0) mask_q <= mask_q - MASK_W'(1);
            else if (mismatch) perr_q <= 1'b1;
        end
    end

    assign lu_valid       = lu_valid_q;
    assign lu_operand_a   = lu_a_q;
    assign lu_operand_b   = lu_b_q;
    assign lu_user        = lu_user_q;
    assign lu_opcode      = lu_opcode_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_error      = rsp_error_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_user       = rsp_user_q;
    assign protocol_error = perr_q;

`ifdef FCORE_LOGIC_ARB_PERF_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_perf
        logic [31:0] grants_q, stalls_q;
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                grants_q <= '0;
                stalls_q <= '0;
            end else begin
                if (grant[i] && grants_q != '1) grants_q <= grants_q + 32'd1;
                if (req_valid[i] && !grant[i] && stalls_q != '1) stalls_q <= stalls_q + 32'd1;
            end
        end
        assign perf_grants[i*32 +: 32] = grants_q;
        assign perf_stalls[i*32 +: 32] = stalls_q;
    end
`endif

endmodule

// File: doc/fcore_logic_arbiter.md
Name: fcore_logic_arbiter

Overview:
- Shares one fCore logic unit (AND/OR/NOT/XOR) between N_REQ issue ports, e.g. several fCore lanes or an fCore plus a debug/config port.
- Round-robin grants at most one operation per cycle and drives the unit's operand_a/operand_b/operation streams.
- Tracks in-flight tags so that each result, or each illegal-opcode error, returns to the requester that issued it, in issue order.
- Sits between the fCore issue stage and the logic unit; the logic unit itself is unchanged.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, operand/result width.
- USER_WIDTH, 16, destination tag forwarded through the unit's user field.
- OPCODE_WIDTH, 4, logic opcode width.
- LU_LATENCY, 1, cycles from unit input valid to unit result valid.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  request valid per requester.
- req_ready  out  N_REQ  grant/ready per requester (combinational).
- req_opcode  in  N_REQ*OPCODE_WIDTH  packed opcodes.
- req_operand_a  in  N_REQ*DATA_WIDTH  packed operand A.
- req_operand_b  in  N_REQ*DATA_WIDTH  packed operand B.
- req_user  in  N_REQ*USER_WIDTH  packed destination tags.
- lu_valid  out  1  drives operand_a.valid of the logic unit.
- lu_operand_a  out  DATA_WIDTH  operand_a.data.
- lu_operand_b  out  DATA_WIDTH  operand_b.data.
- lu_user  out  USER_WIDTH  operand_a.user.
- lu_opcode  out  OPCODE_WIDTH  operation.data.
- lu_result_valid  in  1  result.valid.
- lu_result_data  in  DATA_WIDTH  result.data.
- lu_result_user  in  USER_WIDTH  result.user.
- rsp_valid  out  N_REQ  one-hot response strobe.
- rsp_error  out  N_REQ  one-hot illegal-opcode strobe; coincident with rsp_valid.
- rsp_data  out  DATA_WIDTH  response data, shared by all requesters.
- rsp_user  out  USER_WIDTH  response tag, shared by all requesters.
- protocol_error  out  1  sticky; unit result and tag pipe out of sync.

Behaviour:
- Reset: all outputs 0, pending[] = 0, tag pipe cleared. rr_ptr = N_REQ-1, so requester 0 has first priority.
- Eligibility: eligible[i] = req_valid[i] & ~pending[i].
- Arbitration search order: rr_ptr+1, rr_ptr+2, ... wrapping modulo N_REQ.
- Grant: the first eligible requester g gets req_ready[g] = 1. All other req_ready bits are 0. req_ready must not depend on any other requester's req_ready.
- Handshake (req_valid[g] & req_ready[g]) at edge T:
  - pending[g] <= 1; rr_ptr <= g.
  - A tag {valid, id = g, err} enters the tag pipe, which is LU_LATENCY+1 stages deep.
- Legal opcodes are 0 AND, 1 OR, 2 NOT, 6 XOR. For a legal opcode at edge T:
  - lu_valid <= 1 and operands, user and opcode are registered, so the unit sees them in cycle T+1.
  - The unit result arrives in cycle T+1+LU_LATENCY.
- Illegal opcode (any other value): lu_valid stays 0 and err = 1 in the tag. The tag still transits the pipe so ordering is preserved.
- Response timing: when the tag exits the pipe, the response is registered at the next edge. rsp_valid[id] is high for exactly one cycle, LU_LATENCY+2 cycles after the handshake (3 at default).
- Response content:
  - rsp_error[id] = err.
  - Legal op: rsp_data = lu_result_data, rsp_user = lu_result_user.
  - Illegal op: rsp_data = 0 and rsp_user = the user value captured at handshake.
- pending[id] clears at the same edge that raises rsp_valid[id]. req_ready[id] may therefore assert in the rsp_valid cycle, giving a per-requester issue period of LU_LATENCY+2 cycles.
- Aggregate throughput: 1 op per cycle.
- Idle: with no request, lu_valid = 0 and rr_ptr is held.
- protocol_error sets on either mismatch and clears only on reset:
  - lu_result_valid = 1 while the exiting tag is invalid or has err = 1.
  - An exiting legal tag with lu_result_valid = 0.
- Reset mid-operation:
  - All in-flight tags are dropped and no rsp is generated for them.
  - The protocol_error check is masked for LU_LATENCY+1 cycles after reset release (down-counter), which absorbs stale unit results.
- Simultaneous handshake by requester i and response to i in the same cycle: pending stays set, since the set wins.
- rsp_data and rsp_user return to 0 in cycles with no response.

Optional Feature:
- Macro: FCORE_LOGIC_ARB_PERF_EN.
- Defined: adds output perf_grants (N_REQ*32), per-requester saturating counts of accepted handshakes, and perf_stalls (N_REQ*32), counts of cycles with req_valid & ~req_ready. Both reset to 0 and saturate at 2^32-1.
- Undefined: both ports and the counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fcore_isa gains the opcode constants LU_OP_AND = 0, LU_OP_OR = 1, LU_OP_NOT = 2, LU_OP_XOR = 6, the function is_logic_opcode(), and the typedef lu_tag_t {valid, id, err}.
- One sub-module: fcore_rr_arbiter (combinational round-robin select from eligible[] and rr_ptr; outputs grant one-hot and index), reusable elsewhere.

Test Plan:
- Single request: req 0 AND a=0xF0F0, b=0xFF00, user=0x12 at cycle 0 → rsp_valid[0] at cycle 3, rsp_data=0xF000, rsp_user=0x12, rsp_error=0.
- All 4 requesters valid continuously → grants 0,1,2,3 on consecutive cycles. Each requester is re-granted only after its response, and responses arrive in grant order.
- Illegal opcode 5 from req 2 → lu_valid stays 0; rsp_valid[2] and rsp_error[2] pulse 3 cycles later with rsp_data=0; protocol_error stays 0.
- NOT a=0x0000FFFF from req 1 back-to-back with XOR a=0xAAAA, b=0x5555 from req 3 → rsp 0xFFFF0000 to req 1, then 0x0000FFFF to req 3 one cycle later.
- Inject a spurious lu_result_valid with an empty pipe → protocol_error=1 and held. Pulse reset mid-burst → all outputs 0, no stale rsp_valid, protocol_error cleared.
- With FCORE_LOGIC_ARB_PERF_EN: 10 handshakes from req 0 while req 1 is blocked by pending for 6 cycles → perf_grants[0]=10, perf_stalls[1]=6.
